// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per clock, with a start/busy/done handshake for pipeline stalling.
module muldiv_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       func3,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic                 ovf_q, ovf_d;
    logic [WIDTH-1:0]     src_a_q, src_a_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 signed_a, signed_b, a_neg, b_neg, dz_in, ovf_in;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       msum, trial, diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_s;
    logic [WIDTH-1:0]     quo, rem, fin_val;

    always_comb begin
        signed_a = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) ||
                   (func3 == 3'b110);
        signed_b = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
        a_neg    = signed_a & srcA[WIDTH-1];
        b_neg    = signed_b & srcB[WIDTH-1];
        a_mag    = a_neg ? -srcA : srcA;
        b_mag    = b_neg ? -srcB : srcB;
        dz_in    = func3[2] && (srcB == '0);
        ovf_in   = func3[2] && !func3[0] && (srcA == MinVal) && (srcB == '1);
    end

    // acc holds {product high, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
        mul_next = {msum, acc_q[WIDTH-1:1]};
        trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = trial - {1'b0, b_q};
        if (!diff[WIDTH]) begin
            div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_s = neg_q ? -acc_q : acc_q;
        quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        unique case (op_q)
            3'b000:                 fin_val = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fin_val = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fin_val = dz_q ? '1 : (ovf_q ? src_a_q : quo);
            default:                fin_val = dz_q ? src_a_q : (ovf_q ? '0 : rem);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        src_a_d  = src_a_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (kill) begin
            state_d = StIdle;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_d    = func3;
                        a_d     = a_mag;
                        b_d     = b_mag;
                        acc_d   = {{WIDTH{1'b0}}, (func3[2] ? a_mag : b_mag)};
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        dz_d    = dz_in;
                        ovf_d   = ovf_in;
                        src_a_d = srcA;
                        count_d = '0;
                        busy_d  = 1'b1;
                        state_d = (EARLY_OUT && (dz_in || ovf_in)) ? StFin : StCalc;
                    end
                end
                StCalc: begin
                    count_d = count_q + 1'b1;
                    acc_d   = op_q[2] ? div_next : mul_next;
                    if (count_q == CntW'(WIDTH - 1)) begin
                        state_d = StFin;
                    end
                end
                StFin: begin
                    result_d = fin_val;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            src_a_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            src_a_q  <= src_a_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
